// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK transmit read path: FSM encoding,
// Gray-coded dibit constellation points and default amplitude settings.
package qpsk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CAP  = 2'd2,
    SEND = 2'd3
  } state_t;

  // Dibit {b1,b0} patterns named by the (I,Q) quadrant they select.
  localparam logic [1:0] DIBIT_PP = 2'b00;
  localparam logic [1:0] DIBIT_NP = 2'b01;
  localparam logic [1:0] DIBIT_NN = 2'b11;
  localparam logic [1:0] DIBIT_PN = 2'b10;

  localparam int DEFAULT_AMP       = 64;
  localparam int DEFAULT_AMP_WIDTH = 8;

endpackage

// File: rtl/qpsk_symbol_map.sv
// Gray-coded dibit to signed (I,Q) constellation point; purely combinational
// so the receiver slicer can share it as its reference constellation.
module qpsk_symbol_map
  import qpsk_pkg::*;
#(
  parameter int AMP_WIDTH = DEFAULT_AMP_WIDTH,
  parameter int AMP       = DEFAULT_AMP
) (
  input  logic [1:0]           dibit,
  output logic [AMP_WIDTH-1:0] sym_i,
  output logic [AMP_WIDTH-1:0] sym_q
);

  localparam logic [AMP_WIDTH-1:0] POS = AMP_WIDTH'(AMP);
  localparam logic [AMP_WIDTH-1:0] NEG = AMP_WIDTH'(-AMP);

  always_comb begin
    sym_i = POS;
    sym_q = POS;
    case (dibit)
      DIBIT_PP: begin sym_i = POS; sym_q = POS; end
      DIBIT_NP: begin sym_i = NEG; sym_q = POS; end
      DIBIT_NN: begin sym_i = NEG; sym_q = NEG; end
      DIBIT_PN: begin sym_i = POS; sym_q = NEG; end
      default:  begin sym_i = POS; sym_q = POS; end
    endcase
  end

endmodule

// File: rtl/qpsk_fifo_reader.sv
// Pops words from the transmit byte FIFO, splits them into dibits MSB first
// and streams Gray-mapped I/Q symbols to the pulse shaper over valid/ready.
module qpsk_fifo_reader
  import qpsk_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int AMP_WIDTH  = DEFAULT_AMP_WIDTH,
  parameter int AMP        = DEFAULT_AMP
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read_en,
  output logic                  sym_valid,
  input  logic                  sym_ready,
  output logic [AMP_WIDTH-1:0]  sym_i,
  output logic [AMP_WIDTH-1:0]  sym_q,
  output logic                  sym_last,
  output logic [15:0]           byte_cnt,
  output logic                  busy
);

  localparam int SYMS  = DATA_WIDTH / 2;
  localparam int CNT_W = (SYMS > 1) ? $clog2(SYMS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SYMS - 1);

  state_t                  state;
  logic [DATA_WIDTH-1:0]   shift;
  logic [CNT_W-1:0]        dibit_cnt;
  logic [AMP_WIDTH-1:0]    map_i;
  logic [AMP_WIDTH-1:0]    map_q;
  logic                    at_last;
  logic                    fetch_ok;

  assign at_last  = (dibit_cnt == LAST_IDX);
  assign fetch_ok = enable && !fifo_empty;

  qpsk_symbol_map #(
    .AMP_WIDTH (AMP_WIDTH),
    .AMP       (AMP)
  ) u_map (
    .dibit (shift[DATA_WIDTH-1 -: 2]),
    .sym_i (map_i),
    .sym_q (map_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift     <= '0;
      dibit_cnt <= '0;
      byte_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (fetch_ok) state <= REQ;
        REQ:  state <= CAP;
        CAP: begin
          shift     <= fifo_data;
          dibit_cnt <= '0;
          byte_cnt  <= byte_cnt + 16'd1;
          state     <= SEND;
        end
        SEND: begin
          if (sym_ready) begin
            shift     <= shift << 2;
            dibit_cnt <= dibit_cnt + 1'b1;
            // The empty flag is only trusted here and in IDLE.
            if (at_last) state <= fetch_ok ? REQ : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the state register only, so they are glitch-free and
  // fall with the asynchronous reset; I/Q are forced to zero outside SEND.
  assign fifo_read_en = (state == REQ);
  assign sym_valid    = (state == SEND);
  assign sym_last     = (state == SEND) && at_last;
  assign sym_i        = (state == SEND) ? map_i : '0;
  assign sym_q        = (state == SEND) ? map_q : '0;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_qpsk_fifo_reader.sv
// Directed bench for qpsk_fifo_reader with a 16-deep FIFO model on the read
// side and hand-computed Gray-mapped symbol expectations.
module tb_qpsk_fifo_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        fifo_empty;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_read_en;
  logic        sym_valid;
  logic        sym_ready;
  logic [7:0]  sym_i;
  logic [7:0]  sym_q;
  logic        sym_last;
  logic [15:0] byte_cnt;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] mem [16];
  int wr_cnt     = 0;
  int rd_cnt     = 0;
  int rd_pulses  = 0;
  int empty_viol = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (wr_cnt == rd_cnt);

  always @(posedge clk) begin
    if (fifo_read_en) begin
      if (fifo_empty) empty_viol <= empty_viol + 1;
      else begin
        fifo_data <= mem[rd_cnt % 16];
        rd_cnt    <= rd_cnt + 1;
      end
      rd_pulses <= rd_pulses + 1;
    end
  end

  qpsk_fifo_reader #(.DATA_WIDTH(8), .AMP_WIDTH(8), .AMP(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_read_en (fifo_read_en),
    .sym_valid    (sym_valid),
    .sym_ready    (sym_ready),
    .sym_i        (sym_i),
    .sym_q        (sym_q),
    .sym_last     (sym_last),
    .byte_cnt     (byte_cnt),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_cnt % 16] = d;
    wr_cnt++;
  endtask

  function automatic int exp_i(input logic [1:0] d);
    case (d)
      2'b00: return 64;
      2'b01: return -64;
      2'b11: return -64;
      default: return 64;
    endcase
  endfunction

  function automatic int exp_q(input logic [1:0] d);
    case (d)
      2'b00: return 64;
      2'b01: return 64;
      2'b11: return -64;
      default: return -64;
    endcase
  endfunction

  task automatic wait_valid(input string tag);
    for (int n = 0; n < 20 && !sym_valid; n++) @(negedge clk);
    if (!sym_valid) chk({tag, "_timeout"}, sym_valid, 1);
  endtask

  // Check the presented symbol, then step past its handshake (sym_ready=1).
  task automatic sym_expect(input string tag, input int ei, input int eq, input logic el);
    wait_valid(tag);
    chk({tag, "_i"}, $signed(sym_i), ei);
    chk({tag, "_q"}, $signed(sym_q), eq);
    chk({tag, "_last"}, sym_last, el);
    $display("sym %s: I=%0d Q=%0d last=%0d", tag, $signed(sym_i), $signed(sym_q), sym_last);
    @(negedge clk);
  endtask

  task automatic word_expect(input string tag, input logic [7:0] w);
    for (int d = 3; d >= 0; d--) begin
      logic [1:0] dib;
      dib = w[2*d +: 2];
      sym_expect($sformatf("%s_s%0d", tag, 3 - d), exp_i(dib), exp_q(dib), d == 0);
    end
  endtask

  initial begin
    int base;
    reset     = 1'b0;
    enable    = 1'b1;
    sym_ready = 1'b1;
    push(8'hB4);

    // Reset held with a non-empty FIFO.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rst_read_en", fifo_read_en, 0);
      chk("rst_valid", sym_valid, 0);
      chk("rst_i", sym_i, 0);
      chk("rst_q", sym_q, 0);
      chk("rst_byte_cnt", byte_cnt, 0);
      chk("rst_busy", busy, 0);
    end
    reset = 1'b1;

    // Single word 0xB4, including first-symbol latency.
    @(negedge clk);
    chk("lat_req_read_en", fifo_read_en, 1);
    chk("lat_req_busy", busy, 1);
    @(negedge clk);
    chk("lat_cap_read_en", fifo_read_en, 0);
    chk("lat_cap_valid", sym_valid, 0);
    @(negedge clk);
    chk("lat_send_valid", sym_valid, 1);
    sym_expect("b4_s0",  64, -64, 1'b0);
    sym_expect("b4_s1", -64, -64, 1'b0);
    sym_expect("b4_s2", -64,  64, 1'b0);
    sym_expect("b4_s3",  64,  64, 1'b1);
    chk("b4_busy", busy, 0);
    chk("b4_byte_cnt", byte_cnt, 1);
    chk("b4_pulses", rd_pulses, 1);

    // Backpressure on the second symbol of 0x1B.
    push(8'h1B);
    sym_expect("1b_s0", 64, 64, 1'b0);
    sym_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("bp_i", $signed(sym_i), -64);
      chk("bp_q", $signed(sym_q), 64);
      chk("bp_last", sym_last, 0);
      @(negedge clk);
      chk("bp_valid", sym_valid, 1);
      chk("bp_read_en", fifo_read_en, 0);
    end
    sym_ready = 1'b1;
    sym_expect("1b_s1", -64,  64, 1'b0);
    sym_expect("1b_s2",  64, -64, 1'b0);
    sym_expect("1b_s3", -64, -64, 1'b1);
    chk("1b_pulses", rd_pulses, 2);
    chk("1b_byte_cnt", byte_cnt, 2);

    // Full burst of 15 words.
    enable = 1'b0;
    base = rd_pulses;
    for (int w = 0; w < 15; w++) push(8'(w));
    enable = 1'b1;
    for (int w = 0; w < 15; w++) word_expect($sformatf("burst_w%0d", w), 8'(w));
    repeat (3) @(negedge clk);
    chk("burst_pulses", rd_pulses - base, 15);
    chk("burst_byte_cnt", byte_cnt, 17);
    chk("burst_busy", busy, 0);
    chk("burst_empty_viol", empty_viol, 0);

    // enable dropped during the first symbol of word 2.
    enable = 1'b0;
    base = rd_pulses;
    push(8'h11); push(8'h22); push(8'h33);
    enable = 1'b1;
    word_expect("en_w1", 8'h11);
    wait_valid("en_w2");
    enable = 1'b0;
    word_expect("en_w2", 8'h22);
    repeat (5) @(negedge clk);
    chk("en_pulses", rd_pulses - base, 2);
    chk("en_fifo_left", wr_cnt - rd_cnt, 1);
    chk("en_busy", busy, 0);
    chk("en_byte_cnt", byte_cnt, 19);

    // Drain the leftover word, then reset in the middle of 0xFF.
    enable = 1'b1;
    word_expect("drain", 8'h33);
    enable = 1'b0;
    push(8'hFF); push(8'h00);
    enable = 1'b1;
    sym_expect("ff_s0", -64, -64, 1'b0);
    sym_expect("ff_s1", -64, -64, 1'b0);
    chk("ff_s2_valid", sym_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", sym_valid, 0);
    chk("mid_rst_byte_cnt", byte_cnt, 0);
    chk("mid_rst_i", sym_i, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    word_expect("post_rst", 8'h00);
    chk("post_rst_byte_cnt", byte_cnt, 1);
    chk("post_rst_fifo_left", wr_cnt - rd_cnt, 0);
    chk("post_rst_busy", busy, 0);
    chk("final_empty_viol", empty_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
